// File: rtl/multiplicador_acumulador.sv
// ============================================================================
//  Module      : multiplicador_acumulador
//  Description : Radix-2 shift-add multiply-accumulate, produto = a*b + parcela,
//                with start/ready/done_tick handshake. Optional macro
//                EARLY_EXIT_EN ends OP once the remaining multiplier is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplicador_acumulador #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     fator_a,
    input  logic [W-1:0]     fator_b,
    input  logic [W-1:0]     parcela,
    output logic             ready,
    output logic             done_tick,
    output logic [2*W-1:0]   produto
);

    localparam int            CW         = $clog2(W + 1);
    localparam logic [CW-1:0] C_CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OP   = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q,   state_d;
    logic [2*W-1:0] acc_q,     acc_d;
    logic [2*W-1:0] mcand_q,   mcand_d;
    logic [W-1:0]   mplier_q,  mplier_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic [2*W-1:0] produto_q, produto_d;

    logic [2*W-1:0] acc_step;
    logic [W-1:0]   mplier_shift;
    logic           last_step;

    // One shift-add iteration; max result 2^(2W)-2^W never needs a carry-out.
    always_comb begin
        acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shift = mplier_q >> 1;
`ifdef EARLY_EXIT_EN
        last_step    = (cnt_q == C_CNT_ONE) || (mplier_shift == '0);
`else
        last_step    = (cnt_q == C_CNT_ONE);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            produto_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            produto_q <= produto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_OP;
            S_OP:    if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        produto_d = produto_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = {{W{1'b0}}, parcela};
                    mcand_d  = {{W{1'b0}}, fator_a};
                    mplier_d = fator_b;
                    cnt_d    = C_CNT_LOAD;
                end
            end
            S_OP: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q - C_CNT_ONE;
                if (last_step) produto_d = acc_step;
            end
            default: ;
        endcase
    end

    always_comb begin
        ready     = (state_q == S_IDLE);
        done_tick = (state_q == S_DONE);
        produto   = produto_q;
    end

endmodule

`default_nettype wire
